// File: rtl/uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm
//
// UART transmitter. It serialises one parallel word per frame onto tx_out in
// this order: start bit (0), DATA_WIDTH data bits LSB first, an optional parity
// bit, and one stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles. The
// block contains its own baud-tick divider and bit-index counter.
//
// Ports
//   clk       in   system clock; all logic is on the rising edge
//   hard_rst  in   synchronous, active-high reset; abandons any frame in flight
//   tx_valid  in   client has a word to send (only looked at in IDLE)
//   tx_data   in   word to send; sampled on acceptance
//   tx_ready  out  high only in IDLE
//   tx_out    out  registered serial line, idle-high
//   tx_busy   out  frame in progress (state != IDLE)
//   tx_done   out  one-cycle pulse on the IDLE cycle that follows STOP
// -----------------------------------------------------------------------------
module uart_tx_fsm #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  hard_rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_WIDTH - 1);
    localparam logic             PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_out_q, tx_out_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    // ---- next-state / datapath ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == CNT_MAX);

        // Baud divider runs in every non-IDLE state and wraps on bit_end;
        // since states only change on bit_end, this also clears it on
        // every transition.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_d = tx_data;
                    par_d   = (^tx_data) ^ PAR_INV;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx_out is registered, so it is derived from the state being entered.
        case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shreg_d[0];
            S_PARITY: tx_out_d = par_d;
            default:  tx_out_d = 1'b1;
        endcase
    end

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (hard_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tx_out_q <= tx_out_d;
            done_q   <= done_d;
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm. Four instances with different parameter sets share
// one clock and reset. A frame-level model expands each accepted word into its
// expected per-cycle line waveform; every cycle, all four instances are compared
// against it, and directed literal checks pin the model to hand-derived values.
module tb_uart_tx_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hard_rst;
    logic [3:0]  vld, txo, bsy, rdy, dn;
    logic [15:0] dat [4];

    // 0: 8 bits, 4 clk/bit, even parity   1: same, odd parity
    // 2: 8 bits, 4 clk/bit, no parity     3: 5 bits, 2 clk/bit, even parity
    uart_tx_fsm #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .hard_rst(hard_rst), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_fsm #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_b (
        .clk(clk), .hard_rst(hard_rst), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
        .tx_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_fsm #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_c (
        .clk(clk), .hard_rst(hard_rst), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
        .tx_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_fsm #(.DATA_WIDTH(5), .CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(0)) u_d (
        .clk(clk), .hard_rst(hard_rst), .tx_valid(vld[3]), .tx_data(dat[3][4:0]),
        .tx_ready(rdy[3]), .tx_out(txo[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

    function automatic int f_dw(int k);   return (k == 3) ? 5 : 8; endfunction
    function automatic int f_cpb(int k);  return (k == 3) ? 2 : 4; endfunction
    function automatic int f_pen(int k);  return (k == 2) ? 0 : 1; endfunction
    function automatic int f_podd(int k); return (k == 1) ? 1 : 0; endfunction

    int n_vec = 0;
    int n_err = 0;

    // Model: remaining frame cycles, position in the expected waveform.
    int m_rem [4];
    int m_pos [4];
    bit m_done [4];
    bit m_wave [4][64];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic build(int k, logic [15:0] data);
        bit bits [20];
        int nb;
        bit p;
        p = (f_podd(k) != 0);
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < f_dw(k); i++) begin
            bits[nb] = data[i];
            p = p ^ data[i];
            nb++;
        end
        if (f_pen(k) != 0) begin
            bits[nb] = p;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        for (int i = 0; i < nb; i++)
            for (int r = 0; r < f_cpb(k); r++)
                m_wave[k][i*f_cpb(k) + r] = bits[i];
        m_rem[k] = nb * f_cpb(k);
        m_pos[k] = 0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            if (hard_rst) begin
                m_rem[k]  = 0;
                m_done[k] = 1'b0;
            end else if (m_rem[k] > 0) begin
                m_done[k] = (m_rem[k] == 1);
                m_rem[k]--;
                m_pos[k]++;
            end else begin
                m_done[k] = 1'b0;
                if (vld[k]) build(k, dat[k]);
            end
        end
    endtask

    // One clock: advance the model on the edge, compare all instances 1 ns later.
    task automatic step();
        logic [3:0] e;
        bit busy;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 4; k++) begin
            busy = (m_rem[k] > 0);
            e[3] = busy ? m_wave[k][m_pos[k]] : 1'b1;
            e[2] = busy;
            e[1] = !busy;
            e[0] = m_done[k];
            chk($sformatf("dut%0d_out_busy_ready_done", k),
                {28'd0, txo[k], bsy[k], rdy[k], dn[k]}, {28'd0, e});
        end
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(int k, int budget);
        int n;
        n = 0;
        while (bsy[k] !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("wait_idle_dut%0d", k), {31'd0, bsy[k]}, 32'd0);
    endtask

    initial begin
        logic [0:10] lit_a;
        int bc0, bc1;

        hard_rst = 1'b1;
        vld = 4'b0;
        for (int k = 0; k < 4; k++) begin
            dat[k] = 16'h0;
            m_rem[k] = 0;
            m_pos[k] = 0;
            m_done[k] = 1'b0;
        end

        // Reset state
        steps(2);
        hard_rst = 1'b0;
        chk("rst_tx_out", {31'd0, txo[0]}, 32'd1);
        chk("rst_ready",  {31'd0, rdy[0]}, 32'd1);
        chk("rst_busy",   {31'd0, bsy[0]}, 32'd0);
        chk("rst_done",   {31'd0, dn[0]},  32'd0);
        steps(2);

        // Basic frame 0xA5, even parity
        dat[0] = 16'h00A5;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        lit_a = 11'b01010010101;
        bc0 = 0;
        for (int c = 1; c <= 44; c++) begin
            chk($sformatf("t1_line_c%0d", c), {31'd0, txo[0]}, {31'd0, lit_a[(c-1)/4]});
            if (bsy[0] === 1'b1) bc0++;
            step();
        end
        chk("t1_done_c45",     {31'd0, dn[0]}, 32'd1);
        chk("t1_busy_cycles",  bc0, 44);
        step();
        chk("t1_done_one_cyc", {31'd0, dn[0]}, 32'd0);

        // Odd parity on 0x00, and no-parity frame on 0x00
        dat[1] = 16'h0;
        dat[2] = 16'h0;
        vld[1] = 1'b1;
        vld[2] = 1'b1;
        step();
        vld[1] = 1'b0;
        vld[2] = 1'b0;
        bc0 = 0;
        bc1 = 0;
        for (int c = 1; c <= 44; c++) begin
            if (c >= 37 && c <= 40) begin
                chk("t2_odd_parity_bit", {31'd0, txo[1]}, 32'd1);
                chk("t2_nopar_stop_bit", {31'd0, txo[2]}, 32'd1);
            end
            if (c == 41) chk("t2_nopar_done_c41", {31'd0, dn[2]}, 32'd1);
            if (bsy[1] === 1'b1) bc0++;
            if (bsy[2] === 1'b1) bc1++;
            step();
        end
        chk("t2_odd_done_c45",   {31'd0, dn[1]}, 32'd1);
        chk("t2_odd_busy_cyc",   bc0, 44);
        chk("t2_nopar_busy_cyc", bc1, 40);
        steps(2);

        // Back-to-back with tx_valid held: 0x01 then 0x80
        dat[0] = 16'h0001;
        vld[0] = 1'b1;
        step();
        dat[0] = 16'h0080;
        steps(44);
        chk("t3_gap_done",  {31'd0, dn[0]},  32'd1);
        chk("t3_gap_ready", {31'd0, rdy[0]}, 32'd1);
        chk("t3_gap_line",  {31'd0, txo[0]}, 32'd1);
        step();
        vld[0] = 1'b0;
        chk("t3_second_start", {31'd0, txo[0]}, 32'd0);
        chk("t3_second_busy",  {31'd0, bsy[0]}, 32'd1);
        steps(4);
        chk("t3_second_bit0", {31'd0, txo[0]}, 32'd0);
        steps(28);
        chk("t3_second_bit7", {31'd0, txo[0]}, 32'd1);
        wait_idle(0, 100);
        steps(2);

        // Input activity during a frame is ignored
        dat[0] = 16'h003C;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c % 3 == 0) begin
                vld[0] = ~vld[0];
                dat[0] = 16'(c * 37);
            end
            chk("t4_ready_low", {31'd0, rdy[0]}, 32'd0);
            if (c == 5)  chk("t4_bit0", {31'd0, txo[0]}, 32'd0);
            if (c == 13) chk("t4_bit2", {31'd0, txo[0]}, 32'd1);
            step();
        end
        vld[0] = 1'b0;
        wait_idle(0, 100);
        steps(2);

        // Reset during DATA bit 3, then a clean frame
        dat[0] = 16'h005A;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        steps(17);
        chk("t5_bit3_before_rst", {31'd0, txo[0]}, 32'd1);
        hard_rst = 1'b1;
        step();
        hard_rst = 1'b0;
        chk("t5_rst_line",  {31'd0, txo[0]}, 32'd1);
        chk("t5_rst_busy",  {31'd0, bsy[0]}, 32'd0);
        chk("t5_rst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("t5_rst_done",  {31'd0, dn[0]},  32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_no_done_after_rst", {31'd0, dn[0]}, 32'd0);
        end
        dat[0] = 16'h0096;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        steps(4);
        chk("t5_new_bit0", {31'd0, txo[0]}, 32'd0);
        steps(4);
        chk("t5_new_bit1", {31'd0, txo[0]}, 32'd1);
        wait_idle(0, 100);
        steps(2);

        // 5-bit, 2 clk/bit frame of 0x1F
        dat[3] = 16'h001F;
        vld[3] = 1'b1;
        step();
        vld[3] = 1'b0;
        bc0 = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c <= 2)              chk("t6_start", {31'd0, txo[3]}, 32'd0);
            if (c >= 3 && c <= 12)   chk("t6_data",  {31'd0, txo[3]}, 32'd1);
            if (c == 13 || c == 14)  chk("t6_parity", {31'd0, txo[3]}, 32'd1);
            if (bsy[3] === 1'b1) bc0++;
            step();
        end
        chk("t6_done_c17",   {31'd0, dn[3]}, 32'd1);
        chk("t6_busy_cycles", bc0, 16);
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
